// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the PC/ROM stage and decode: a DEPTH-entry FIFO of {pc, inst}.
// Optional macro IFQ_BYPASS_EN forwards a fetch straight to decode when the queue is empty.
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AW-1:0]              pc_i,
   input  logic                       ce_i,
   input  logic [DW-1:0]              inst_i,
   output logic                       in_ready_o,
   input  logic                       flush_i,
   output logic                       id_valid_o,
   input  logic                       id_ready_i,
   output logic [AW-1:0]              id_pc_o,
   output logic [DW-1:0]              id_inst_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] mem_pc   [DEPTH];
   logic [DW-1:0] mem_inst [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          q_valid;
   logic          push;
   logic          pop;
   logic          push_q;
   logic          pop_q;

   assign q_valid    = (count != '0);
   assign in_ready_o = (count < CW'(DEPTH));
   assign count_o    = count;

   always_comb begin
      id_valid_o = q_valid;
      id_pc_o    = '0;
      id_inst_o  = '0;
      if (q_valid) begin
         id_pc_o   = mem_pc[rptr];
         id_inst_o = mem_inst[rptr];
      end
`ifdef IFQ_BYPASS_EN
      if (!q_valid && ce_i && !flush_i) begin
         id_valid_o = 1'b1;
         id_pc_o    = pc_i;
         id_inst_o  = inst_i;
      end
`endif
   end

   always_comb begin
      push   = ce_i & in_ready_o & ~flush_i;
      pop    = id_valid_o & id_ready_i & ~flush_i;
      push_q = push;
      pop_q  = pop;
`ifdef IFQ_BYPASS_EN
      // A bypassed fetch consumed by decode this cycle never touches the storage.
      if (!q_valid) begin
         push_q = push & ~id_ready_i;
         pop_q  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         count <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         count <= count + CW'(push_q) - CW'(pop_q);
         if (push_q) wptr <= wptr + PW'(1);
         if (pop_q)  rptr <= rptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_q) begin
         mem_pc[wptr]   <= pc_i;
         mem_inst[wptr] <= inst_i;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4, AW=DW=32); honours IFQ_BYPASS_EN if defined.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = '0;
   logic        ce_i = 1'b0;
   logic [31:0] inst_i = '0;
   logic        in_ready_o;
   logic        flush_i = 1'b0;
   logic        id_valid_o;
   logic        id_ready_i = 1'b0;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic [2:0]  count_o;

   int unsigned checks = 0;
   int unsigned failures = 0;

   // Drain schedule: upstream holds 0x10 while the full queue cannot accept.
   logic        dce  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [31:0] dpc  [8] = '{32'h10, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h0, 32'h0, 32'h0};
   logic [2:0]  dcnt [8] = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1};
   logic [31:0] epc  [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
   logic [31:0] einst[8] = '{32'h11, 32'h22, 32'h33, 32'h44,
                             32'h1010, 32'h1014, 32'h1018, 32'h101C};

   inst_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_i       (pc_i),
      .ce_i       (ce_i),
      .inst_i     (inst_i),
      .in_ready_o (in_ready_o),
      .flush_i    (flush_i),
      .id_valid_o (id_valid_o),
      .id_ready_i (id_ready_i),
      .id_pc_o    (id_pc_o),
      .id_inst_o  (id_inst_o),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: two cycles high
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_valid", 64'(id_valid_o), 64'd0);
      check("rst_ready", 64'(in_ready_o), 64'd1);
      check("rst_inst", 64'(id_inst_o), 64'd0);
      check("rst_pc", 64'(id_pc_o), 64'd0);

      // Fill four entries with decode stalled
      id_ready_i = 1'b0;
      ce_i = 1'b1; pc_i = 32'h0; inst_i = 32'h11;
      #1;
`ifdef IFQ_BYPASS_EN
      check("fill_first_valid", 64'(id_valid_o), 64'd1);
`else
      check("fill_first_valid", 64'(id_valid_o), 64'd0);
`endif
      for (int i = 0; i < 4; i++) begin
         pc_i = 32'(i * 4); inst_i = 32'((i + 1) * 32'h11);
         tick();
      end
      pc_i = 32'h10; inst_i = 32'h55;
      #1;
      check("full_count", 64'(count_o), 64'd4);
      check("full_ready", 64'(in_ready_o), 64'd0);
      check("full_valid", 64'(id_valid_o), 64'd1);
      check("full_head_pc", 64'(id_pc_o), 64'h0);
      check("full_head_inst", 64'(id_inst_o), 64'h11);
      tick();
      check("fifth_count", 64'(count_o), 64'd4);
      check("fifth_head_pc", 64'(id_pc_o), 64'h0);

      // Drain with wrap-around pushes
      id_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ce_i = dce[k]; pc_i = dpc[k]; inst_i = 32'h1000 | dpc[k];
         #1;
         check($sformatf("drain%0d_count", k), 64'(count_o), 64'(dcnt[k]));
         check($sformatf("drain%0d_ready", k), 64'(in_ready_o), 64'(dcnt[k] != 3'd4));
         check($sformatf("drain%0d_valid", k), 64'(id_valid_o), 64'd1);
         check($sformatf("drain%0d_pc", k), 64'(id_pc_o), 64'(epc[k]));
         check($sformatf("drain%0d_inst", k), 64'(id_inst_o), 64'(einst[k]));
         tick();
      end
      ce_i = 1'b0; id_ready_i = 1'b0;
      #1;
      check("drained_count", 64'(count_o), 64'd0);
      check("drained_valid", 64'(id_valid_o), 64'd0);
      check("drained_pc", 64'(id_pc_o), 64'd0);

      // Flush with a same-cycle fetch
      ce_i = 1'b1;
      pc_i = 32'h20; inst_i = 32'h120; tick();
      pc_i = 32'h24; inst_i = 32'h124; tick();
      pc_i = 32'h28; inst_i = 32'h128; tick();
      check("preflush_count", 64'(count_o), 64'd3);
      flush_i = 1'b1; pc_i = 32'h40; inst_i = 32'h140; id_ready_i = 1'b1;
      tick();
      flush_i = 1'b0; ce_i = 1'b0; id_ready_i = 1'b0;
      #1;
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_valid", 64'(id_valid_o), 64'd0);
      check("flush_pc", 64'(id_pc_o), 64'd0);
      check("flush_ready", 64'(in_ready_o), 64'd1);
      ce_i = 1'b1; pc_i = 32'h50; inst_i = 32'h150;
      tick();
      ce_i = 1'b0;
      #1;
      check("postflush_count", 64'(count_o), 64'd1);
      check("postflush_pc", 64'(id_pc_o), 64'h50);
      check("postflush_inst", 64'(id_inst_o), 64'h150);
      id_ready_i = 1'b1;
      tick();
      check("postflush_empty", 64'(count_o), 64'd0);

      // Empty-queue fetch latency / bypass
      ce_i = 1'b1; pc_i = 32'h80; inst_i = 32'h24080001; id_ready_i = 1'b1;
      #1;
`ifdef IFQ_BYPASS_EN
      check("byp_valid", 64'(id_valid_o), 64'd1);
      check("byp_pc", 64'(id_pc_o), 64'h80);
      check("byp_inst", 64'(id_inst_o), 64'h24080001);
      tick();
      ce_i = 1'b0;
      #1;
      check("byp_count", 64'(count_o), 64'd0);
      check("byp_after_valid", 64'(id_valid_o), 64'd0);
`else
      check("lat_valid0", 64'(id_valid_o), 64'd0);
      check("lat_pc0", 64'(id_pc_o), 64'd0);
      tick();
      ce_i = 1'b0;
      #1;
      check("lat_valid1", 64'(id_valid_o), 64'd1);
      check("lat_pc1", 64'(id_pc_o), 64'h80);
      check("lat_inst1", 64'(id_inst_o), 64'h24080001);
      check("lat_count1", 64'(count_o), 64'd1);
      tick();
      check("lat_popped", 64'(count_o), 64'd0);
`endif

      // Reset mid-operation beats flush, push and pop
      id_ready_i = 1'b0; ce_i = 1'b1;
      pc_i = 32'h90; inst_i = 32'h190; tick();
      pc_i = 32'h94; inst_i = 32'h194; tick();
      check("prerst_count", 64'(count_o), 64'd2);
      rst = 1'b1; flush_i = 1'b1; pc_i = 32'h98; inst_i = 32'h198; id_ready_i = 1'b1;
      tick();
      rst = 1'b0; flush_i = 1'b0; ce_i = 1'b0; id_ready_i = 1'b0;
      #1;
      check("mrst_count", 64'(count_o), 64'd0);
      check("mrst_valid", 64'(id_valid_o), 64'd0);
      check("mrst_pc", 64'(id_pc_o), 64'd0);
      check("mrst_inst", 64'(id_inst_o), 64'd0);
      check("mrst_ready", 64'(in_ready_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
